// File: rtl/network_pkg.sv
// Purpose: shared types and width helpers for the forward-pass sequencing logic.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: sched_state_t (scheduler FSM states) and width helpers used to
// size the layer index, cache strobe vector and watchdog counter.
package network_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_START,
      ST_SETTLE,
      ST_WAIT,
      ST_CACHE,
      ST_LATCH
   } sched_state_t;

   // $clog2 with a floor of 1 so a single-layer network still has a 1-bit index.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int layer_width(input int n_layers);
      return clog2_min1(n_layers);
   endfunction

   // One cache strobe per layer boundary; kept at least 1 bit wide.
   function automatic int cache_width(input int n_layers);
      return (n_layers > 1) ? (n_layers - 1) : 1;
   endfunction

   function automatic int timer_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Purpose: clearable saturating up-counter used as the per-layer watchdog.
// Latency: expired is a decode of the registered count (no input->output path).
// Backpressure: none; inc is sampled every cycle.
//
// Ports: clk, rst (sync active-low), clr (zero the count), inc (count this
// cycle), expired (high while the cycle being counted is the TIMEOUT-th one).
module wait_timer
   import network_pkg::*;
#(
   parameter int TIMEOUT = 1023
)
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = timer_width(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != SAT)) begin
         count <= count + CW'(1);
      end
   end

   // count holds the number of cycles already counted, so when it equals
   // TIMEOUT-1 the cycle being counted right now is the TIMEOUT-th.
   assign expired = (count == LAST);

endmodule

// File: rtl/forward_pass_scheduler.sv
// Purpose: sequences one forward pass (shift, per-layer start/wait/cache, latch) per sample tick.
// Latency: strobes appear the cycle after the registered state reaches them; tick->lsb_shift is 1 cycle.
// Backpressure: none upstream; ticks arriving mid-pass are dropped and flagged as overrun.
//
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   sample_tick       one-cycle pulse per new audio sample
//   conv_done         per-layer out_v level from each conv1d
//   err_clear         clears the sticky overrun / timeout_err flags
//   lsb_shift         pulse: clock the input left shift buffers
//   conv_start        one-hot pulse: start conv for the current layer
//   cache_shift       one-hot pulse: clock activation cache after layer l
//   out_latch         pulse: capture last layer output
//   busy              high while a pass is in progress
//   layer             index of the layer being sequenced
//   overrun           sticky: tick arrived while busy
//   timeout_err       sticky: a layer was aborted by the watchdog
module forward_pass_scheduler
   import network_pkg::*;
#(
   parameter int N_LAYERS = 4,
   parameter int TIMEOUT  = 1023
)
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                sample_tick,
   input  logic [N_LAYERS-1:0]                 conv_done,
   input  logic                                err_clear,
   output logic                                lsb_shift,
   output logic [N_LAYERS-1:0]                 conv_start,
   output logic [cache_width(N_LAYERS)-1:0]    cache_shift,
   output logic                                out_latch,
   output logic                                busy,
   output logic [layer_width(N_LAYERS)-1:0]    layer,
   output logic                                overrun,
   output logic                                timeout_err
);

   localparam int LW = layer_width(N_LAYERS);
   localparam int CW = cache_width(N_LAYERS);
   localparam logic [LW-1:0] LAST_LAYER = LW'(N_LAYERS - 1);

   sched_state_t  state_q, state_d;
   logic [LW-1:0] layer_q, layer_d;
   logic          tmr_clr;
   logic          tmr_inc;
   logic          tmr_expired;
   logic          abort;
   logic          ovr_set;

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .inc     (tmr_inc),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         layer_q <= '0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      tmr_clr = 1'b0;
      tmr_inc = 1'b0;
      abort   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sample_tick) begin
               state_d = ST_SHIFT;
               layer_d = '0;
            end
         end
         ST_SHIFT: begin
            state_d = ST_START;
         end
         ST_START: begin
            tmr_clr = 1'b1;
            state_d = ST_SETTLE;
         end
         // out_v from the previous pass is still high here, so conv_done
         // is deliberately not looked at for one cycle.
         ST_SETTLE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            tmr_inc = 1'b1;
            // A done seen on the very cycle the watchdog expires still wins.
            if (conv_done[layer_q]) begin
               state_d = (layer_q == LAST_LAYER) ? ST_LATCH : ST_CACHE;
            end else if (tmr_expired) begin
               abort   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_CACHE: begin
            layer_d = layer_q + LW'(1);
            state_d = ST_START;
         end
         ST_LATCH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Strobes are pure decodes of registered state and layer.
   always_comb begin
      conv_start  = '0;
      cache_shift = '0;
      for (int i = 0; i < N_LAYERS; i++) begin
         conv_start[i] = (state_q == ST_START) && (layer_q == LW'(i));
      end
      for (int i = 0; i < CW; i++) begin
         cache_shift[i] = (state_q == ST_CACHE) && (layer_q == LW'(i));
      end
   end

   assign lsb_shift = (state_q == ST_SHIFT);
   assign out_latch = (state_q == ST_LATCH);
   assign busy      = (state_q != ST_IDLE);
   assign layer     = layer_q;

   // Any tick outside IDLE is lost, including one landing on the LATCH cycle.
   assign ovr_set = sample_tick && (state_q != ST_IDLE);

   // Set has priority over err_clear so a coincident new error is not lost.
   always_ff @(posedge clk) begin
      if (!rst) begin
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (ovr_set) begin
            overrun <= 1'b1;
         end else if (err_clear) begin
            overrun <= 1'b0;
         end
         if (abort) begin
            timeout_err <= 1'b1;
         end else if (err_clear) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_forward_pass_scheduler.sv
// Purpose: directed scoreboard bench for forward_pass_scheduler (N_LAYERS=2, TIMEOUT=8).
// Latency: expected strobes are queued with the cycle they must appear in.
// Backpressure: n/a.
module tb_forward_pass_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_tick;
   logic [1:0] conv_done;
   logic       err_clear;
   logic       lsb_shift;
   logic [1:0] conv_start;
   logic [0:0] cache_shift;
   logic       out_latch;
   logic       busy;
   logic [0:0] layer;
   logic       overrun;
   logic       timeout_err;

   forward_pass_scheduler #(
      .N_LAYERS (2),
      .TIMEOUT  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .conv_done   (conv_done),
      .err_clear   (err_clear),
      .lsb_shift   (lsb_shift),
      .conv_start  (conv_start),
      .cache_shift (cache_shift),
      .out_latch   (out_latch),
      .busy        (busy),
      .layer       (layer),
      .overrun     (overrun),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // cyc = N during the clock period that follows the N-th rising edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe word: {out_latch, cache_shift[0], conv_start[1], conv_start[0], lsb_shift}
   localparam logic [4:0] E_LSB = 5'b00001;
   localparam logic [4:0] E_CS0 = 5'b00010;
   localparam logic [4:0] E_CS1 = 5'b00100;
   localparam logic [4:0] E_CA0 = 5'b01000;
   localparam logic [4:0] E_LAT = 5'b10000;

   logic [4:0] strobes;
   assign strobes = {out_latch, cache_shift[0], conv_start, lsb_shift};

   typedef struct {
      int         c;
      logic [4:0] s;
   } ev_t;

   ev_t sb[$];
   ev_t e_mon;
   int  n_cmp = 0;
   int  n_err = 0;
   int  t;

   task automatic push_ev(input int c, input logic [4:0] s);
      ev_t e;
      e.c = c;
      e.s = s;
      sb.push_back(e);
   endtask

   // Expected strobes for a pass with conv_done held high for both layers.
   task automatic short_pass_exp(input int t0);
      push_ev(t0 + 1, E_LSB);
      push_ev(t0 + 2, E_CS0);
      push_ev(t0 + 5, E_CA0);
      push_ev(t0 + 6, E_CS1);
      push_ev(t0 + 9, E_LAT);
   endtask

   task automatic go_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every cycle with any strobe high must match the next queued event.
   always @(negedge clk) begin
      if ((|strobes) === 1'b1) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL strobe: unexpected %b at cycle %0d", strobes, cyc);
         end else begin
            e_mon = sb.pop_front();
            if (e_mon.c != cyc || e_mon.s !== strobes) begin
               n_err++;
               $display("FAIL strobe: got %b at cycle %0d expected %b at cycle %0d",
                        strobes, cyc, e_mon.s, e_mon.c);
            end
         end
      end
   end

   initial begin
      rst         = 1'b0;
      sample_tick = 1'b0;
      conv_done   = 2'b00;
      err_clear   = 1'b0;

      // Reset state
      go_to(3);
      chk("reset_strobes", strobes, 0);
      chk("reset_busy", busy, 0);
      chk("reset_layer", layer, 0);
      chk("reset_overrun", overrun, 0);
      chk("reset_timeout", timeout_err, 0);
      rst = 1'b1;

      // 1: done asserted on the 5th WAIT cycle of each layer
      t = 5;
      go_to(t);
      sample_tick = 1'b1;
      push_ev(t + 1, E_LSB);
      push_ev(t + 2, E_CS0);
      push_ev(t + 9, E_CA0);
      push_ev(t + 10, E_CS1);
      push_ev(t + 17, E_LAT);
      go_to(t + 1);
      sample_tick = 1'b0;
      go_to(t + 8);
      conv_done = 2'b01;
      go_to(t + 10);
      chk("t1_layer1", layer, 1);
      go_to(t + 16);
      conv_done = 2'b11;
      go_to(t + 17);
      chk("t1_busy_latch", busy, 1);
      go_to(t + 18);
      chk("t1_busy_idle", busy, 0);

      // 2: stale done high through START/SETTLE, one WAIT cycle per layer
      t = 30;
      go_to(t);
      sample_tick = 1'b1;
      short_pass_exp(t);
      go_to(t + 1);
      sample_tick = 1'b0;
      go_to(t + 9);
      chk("t2_busy_latch", busy, 1);
      go_to(t + 10);
      chk("t2_busy_idle", busy, 0);

      // 3: second tick during WAIT of layer 0
      t = 45;
      go_to(t);
      conv_done   = 2'b00;
      sample_tick = 1'b1;
      push_ev(t + 1, E_LSB);
      push_ev(t + 2, E_CS0);
      push_ev(t + 7, E_CA0);
      push_ev(t + 8, E_CS1);
      push_ev(t + 11, E_LAT);
      go_to(t + 1);
      sample_tick = 1'b0;
      go_to(t + 5);
      chk("t3_overrun_pre", overrun, 0);
      sample_tick = 1'b1;
      go_to(t + 6);
      sample_tick = 1'b0;
      conv_done   = 2'b01;
      chk("t3_overrun_set", overrun, 1);
      go_to(t + 10);
      conv_done = 2'b11;
      go_to(t + 12);
      chk("t3_busy_idle", busy, 0);
      chk("t3_overrun_sticky", overrun, 1);
      chk("t3_timeout_clean", timeout_err, 0);
      err_clear = 1'b1;
      go_to(t + 13);
      err_clear = 1'b0;
      chk("t3_overrun_clear", overrun, 0);

      // 4: layer 1 never completes -> watchdog abort after 8 WAIT cycles
      t = 65;
      go_to(t);
      conv_done   = 2'b01;
      sample_tick = 1'b1;
      push_ev(t + 1, E_LSB);
      push_ev(t + 2, E_CS0);
      push_ev(t + 5, E_CA0);
      push_ev(t + 6, E_CS1);
      go_to(t + 1);
      sample_tick = 1'b0;
      go_to(t + 15);
      chk("t4_timeout_pre", timeout_err, 0);
      chk("t4_busy_wait8", busy, 1);
      go_to(t + 16);
      chk("t4_timeout_set", timeout_err, 1);
      chk("t4_busy_idle", busy, 0);
      go_to(t + 17);
      conv_done   = 2'b11;
      sample_tick = 1'b1;
      short_pass_exp(t + 17);
      go_to(t + 18);
      sample_tick = 1'b0;
      go_to(t + 27);
      chk("t4_rerun_idle", busy, 0);
      chk("t4_timeout_sticky", timeout_err, 1);
      err_clear = 1'b1;
      go_to(t + 28);
      err_clear = 1'b0;
      chk("t4_timeout_clear", timeout_err, 0);

      // 5: reset during SETTLE of layer 1
      t = 100;
      go_to(t);
      sample_tick = 1'b1;
      push_ev(t + 1, E_LSB);
      push_ev(t + 2, E_CS0);
      push_ev(t + 5, E_CA0);
      push_ev(t + 6, E_CS1);
      go_to(t + 1);
      sample_tick = 1'b0;
      go_to(t + 4);
      sample_tick = 1'b1;
      go_to(t + 5);
      sample_tick = 1'b0;
      go_to(t + 7);
      chk("t5_overrun_pre", overrun, 1);
      chk("t5_layer_pre", layer, 1);
      rst = 1'b0;
      go_to(t + 8);
      rst = 1'b1;
      chk("t5_rst_strobes", strobes, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_layer", layer, 0);
      chk("t5_rst_overrun", overrun, 0);
      chk("t5_rst_timeout", timeout_err, 0);
      go_to(t + 10);
      sample_tick = 1'b1;
      short_pass_exp(t + 10);
      go_to(t + 11);
      sample_tick = 1'b0;
      go_to(t + 20);
      chk("t5_rerun_idle", busy, 0);

      // 6: tick coincident with LATCH
      t = 125;
      go_to(t);
      sample_tick = 1'b1;
      short_pass_exp(t);
      go_to(t + 1);
      sample_tick = 1'b0;
      go_to(t + 9);
      chk("t6_overrun_pre", overrun, 0);
      sample_tick = 1'b1;
      go_to(t + 10);
      sample_tick = 1'b0;
      chk("t6_overrun_set", overrun, 1);
      chk("t6_busy_idle", busy, 0);
      go_to(t + 14);
      chk("t6_no_restart", busy, 0);

      go_to(145);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
